// File: rtl/display_scan_controller.sv
// Two-digit seven-segment scan scheduler: blank/show slot FSM with
// frame-boundary promotion of a staged digit pair into the displayed shadow.

module display_digit_reg #(
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             promote,
  input  logic [VEC_W-1:0] d,
  output logic [VEC_W-1:0] h
);
  logic [VEC_W-1:0] s;

  // promote reads the pre-edge staging value, so a same-edge load waits a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= '0;
      h <= '0;
    end else begin
      if (load)    s <= d;
      if (promote) h <= s;
    end
  end
endmodule

module display_scan_controller #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic       an1,
  output logic       an2,
  output logic [3:0] digit,
  output logic       pending,
  output logic       load_ack,
  output logic       frame_start
);
  localparam int NUM_DIGITS = 2;
  localparam int VEC_W      = 4;
  localparam int CW         = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SLOT_CYCLES - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {BLANK_A, SHOW_A, BLANK_B, SHOW_B} state_t;

  typedef struct packed {
    logic                                load;
    logic [NUM_DIGITS-1:0][VEC_W-1:0] d;
  } pair_req_t;

  state_t                           state;
  logic [CW-1:0]                    cnt;
  pair_req_t                        req;
  logic [NUM_DIGITS-1:0][VEC_W-1:0] shadow;
  logic                             in_blank, slot_end, boundary, promote;

  assign req      = '{load: load, d: {d1, d0}};
  assign in_blank = (state == BLANK_A) || (state == BLANK_B);
  assign slot_end = in_blank ? (cnt == BLANK_LAST) : (cnt == SHOW_LAST);
  assign boundary = (state == SHOW_B) && slot_end;
  assign promote  = boundary && pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BLANK_A;
      cnt         <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      load_ack    <= promote;
      frame_start <= boundary;
      if (slot_end) begin
        cnt <= '0;
        case (state)
          BLANK_A: state <= SHOW_A;
          SHOW_A:  state <= BLANK_B;
          BLANK_B: state <= SHOW_B;
          default: state <= BLANK_A;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
      // a load on the boundary edge re-arms pending for the next frame
      if (req.load)     pending <= 1'b1;
      else if (promote) pending <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    display_digit_reg #(.VEC_W(VEC_W)) u_dig (
      .clk     (clk),
      .reset   (reset),
      .load    (req.load),
      .promote (promote),
      .d       (req.d[g]),
      .h       (shadow[g])
    );
  end

  // digit switches at the start of blanking so the decoder settles before the anode enables
  assign an1   = (state != SHOW_A);
  assign an2   = (state != SHOW_B);
  assign digit = (state == BLANK_A || state == SHOW_A) ? shadow[0] : shadow[1];
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with SLOT_CYCLES=8, BLANK_CYCLES=2.
module tb_display_scan_controller;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * SLOT;

  logic       clk = 1'b0, reset = 1'b0, load = 1'b0;
  logic [3:0] d0 = 4'h0, d1 = 4'h0;
  logic       an1, an2, pending, load_ack, frame_start;
  logic [3:0] digit;

  always #5 clk = ~clk;

  display_scan_controller #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset), .load(load), .d0(d0), .d1(d1),
    .an1(an1), .an2(an2), .digit(digit), .pending(pending),
    .load_ack(load_ack), .frame_start(frame_start)
  );

  typedef struct packed {
    logic       an1;
    logic       an2;
    logic [3:0] digit;
    logic       pending;
    logic       ack;
    logic       fs;
  } out_t;

  typedef struct {
    int         l1_e;
    logic [3:0] l1_d0, l1_d1;
    int         l2_e;
    logic [3:0] l2_d0, l2_d1;
    int         n;
    int         ack_e;
    logic [3:0] h0, h1;
  } vec_t;

  localparam out_t RST_OUT = '{an1: 1'b1, an2: 1'b1, digit: 4'h0,
                               pending: 1'b0, ack: 1'b0, fs: 1'b0};

  int         tests = 0, fails = 0;
  int         e;
  out_t       sbq[$];
  logic       m_pend;
  logic [3:0] m_s0, m_s1, m_h0, m_h1;
  int         blank_run, ack_cnt, first_ack, chk_a, chk_b;
  logic [3:0] cap_a, cap_b;

  function automatic out_t dut_out();
    return out_t'({an1, an2, digit, pending, load_ack, frame_start});
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input out_t got, input out_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got an1/an2/digit/pend/ack/fs=%b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    check_out("reset_state", dut_out(), RST_OUT);
    reset  = 1'b1;
    e      = 0;
    m_pend = 1'b0;
    {m_s0, m_s1, m_h0, m_h1} = '0;
    sbq.delete();
    blank_run = 1;
    ack_cnt   = 0;
    first_ack = -1;
    cap_a     = 4'hF;
    cap_b     = 4'hF;
  endtask

  // drives one edge: model predicts post-edge outputs, pushed to the scoreboard
  task automatic step(input logic ld, input logic [3:0] a, input logic [3:0] b);
    out_t x;
    int   p;
    logic bnd, ak;
    load = ld; d0 = a; d1 = b;
    p   = (e + 1) % FRAME;
    bnd = (p == 0);
    ak  = bnd && m_pend;
    if (ak) begin m_h0 = m_s0; m_h1 = m_s1; end
    if (ld) begin m_s0 = a; m_s1 = b; m_pend = 1'b1; end
    else if (ak) m_pend = 1'b0;
    x.an1     = !(p >= BLANK && p < SLOT);
    x.an2     = !(p >= SLOT + BLANK);
    x.digit   = (p < SLOT) ? m_h0 : m_h1;
    x.pending = m_pend;
    x.ack     = ak;
    x.fs      = bnd;
    sbq.push_back(x);
    @(posedge clk);
    e++;
    @(negedge clk);
    x = sbq.pop_front();
    check_out($sformatf("edge%0d", e), dut_out(), x);
    if (load_ack) begin
      ack_cnt++;
      if (first_ack < 0) first_ack = e;
    end
    if (e == chk_a) cap_a = digit;
    if (e == chk_b) cap_b = digit;
    check("both_anodes_low", int'(!an1 && !an2), 0);
    if (an1 && an2) blank_run++;
    else begin
      if (blank_run > 0) check($sformatf("blank_len_e%0d", e), blank_run, BLANK);
      blank_run = 0;
    end
  endtask

  initial begin
    vec_t vt[4];
    vt[0] = '{-1, 4'h0, 4'h0, -1, 4'h0, 4'h0, 30, -1, 4'h0, 4'h0};
    vt[1] = '{ 5, 4'h3, 4'hA, -1, 4'h0, 4'h0, 30, 16, 4'h3, 4'hA};
    vt[2] = '{ 3, 4'h1, 4'h2,  9, 4'h7, 4'hE, 30, 16, 4'h7, 4'hE};
    vt[3] = '{16, 4'h5, 4'h6, -1, 4'h0, 4'h0, 44, 32, 4'h5, 4'h6};

    for (int i = 0; i < 4; i++) begin
      do_reset();
      chk_a = ((vt[i].ack_e > 0) ? vt[i].ack_e : FRAME) + 2;
      chk_b = chk_a + SLOT;
      for (int k = 1; k <= vt[i].n; k++) begin
        if (k == vt[i].l1_e)      step(1'b1, vt[i].l1_d0, vt[i].l1_d1);
        else if (k == vt[i].l2_e) step(1'b1, vt[i].l2_d0, vt[i].l2_d1);
        else                      step(1'b0, 4'h0, 4'h0);
      end
      load = 1'b0;
      check($sformatf("v%0d_ack_count", i), ack_cnt, (vt[i].ack_e > 0) ? 1 : 0);
      check($sformatf("v%0d_ack_edge", i), first_ack, vt[i].ack_e);
      check($sformatf("v%0d_digit0", i), int'(cap_a), int'(vt[i].h0));
      check($sformatf("v%0d_digit1", i), int'(cap_b), int'(vt[i].h1));
    end

    // async reset mid-SHOW_B with a staged pair pending and a nonzero shown digit
    do_reset();
    chk_a = -1; chk_b = -1;
    for (int k = 1; k <= 28; k++) begin
      if (k == 5)       step(1'b1, 4'h3, 4'hA);
      else if (k == 20) step(1'b1, 4'h5, 4'h6);
      else              step(1'b0, 4'h0, 4'h0);
    end
    load = 1'b0;
    check("pre_reset_digit", int'(digit), 4'hA);
    check("pre_reset_pending", int'(pending), 1);
    #2 reset = 1'b0;
    #1 check_out("async_reset", dut_out(), RST_OUT);
    do_reset();
    for (int k = 1; k <= 20; k++) step(1'b0, 4'h0, 4'h0);

    // ten frames with random loads: anode exclusivity and blank length
    do_reset();
    for (int k = 1; k <= 10 * FRAME; k++)
      step($urandom_range(0, 6) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
